// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe: producer side of the EX-stage operand bypass.
// Holds the EX/MEM and MEM/WB pipeline registers, detects load-use hazards
// and runs the data-memory wait handshake with a bounded timeout.
// Optional stall statistics counters: define FWD_STALL_STATS_EN.
module fwd_source_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWrite_EX,
    input  logic [REG_AW-1:0] RegWriteAddr_EX,
    input  logic [DATA_W-1:0] ALUOut_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic [DATA_W-1:0] MemWriteData_EX,
    input  logic [REG_AW-1:0] rs_ID,
    input  logic [REG_AW-1:0] rt_ID,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic              MemReady,
    output logic [DATA_W-1:0] ALUOut_MEM,
    output logic              RegWrite_MEM,
    output logic [REG_AW-1:0] RegWriteAddr_MEM,
    output logic              MemRead_MEM,
    output logic              MemWrite_MEM,
    output logic [DATA_W-1:0] MemWriteData_MEM,
    output logic [DATA_W-1:0] RegWriteData_WB,
    output logic              RegWrite_WB,
    output logic [REG_AW-1:0] RegWriteAddr_WB,
    output logic              Stall_IF_ID,
    output logic              Bubble_ID_EX,
    output logic              StallAll,
    output logic              MemTimeout,
    output logic [31:0]       LoadUseCount,
    output logic [31:0]       MemWaitCount
);

    typedef enum logic [0:0] {StRun, StWait} state_t;

    // The RUN cycle that detects the miss is itself a stall cycle, so the
    // WAIT counter (cleared on entry) ends one short of MEM_TIMEOUT.
    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    state_t     state, stateNext;
    logic [7:0] waitCnt, waitCntNext;
    logic       memBusy;
    logic       timeoutHit;
    logic       regWriteNonZero;
    logic       loadUse;

    // Memory handshake, stall and load-use decode
    always_comb begin
        memBusy         = MemRead_MEM | MemWrite_MEM;
        timeoutHit      = (state == StWait) & memBusy & ~MemReady & (waitCnt == TimeoutLast);
        StallAll        = memBusy & ~MemReady & ~timeoutHit;
        MemTimeout      = timeoutHit;
        regWriteNonZero = RegWrite_EX & (RegWriteAddr_EX != '0);
        // Gated by reset so every output reads 0 while reset is held.
        loadUse         = reset_n & MemRead_EX & regWriteNonZero &
                          ((RegWriteAddr_EX == rs_ID) | (RegWriteAddr_EX == rt_ID));
        Stall_IF_ID     = loadUse | StallAll;
        Bubble_ID_EX    = loadUse & ~StallAll;
    end

    // Wait FSM next-state and wait counter
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        unique case (state)
            StRun: begin
                waitCntNext = '0;
                if (memBusy & ~MemReady) stateNext = StWait;
            end
            StWait: begin
                if (MemReady | timeoutHit | ~memBusy) begin
                    stateNext   = StRun;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            default: begin
                stateNext   = StRun;
                waitCntNext = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StRun;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // EX/MEM register: holds every field while memory stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ALUOut_MEM       <= '0;
            RegWrite_MEM     <= 1'b0;
            RegWriteAddr_MEM <= '0;
            MemRead_MEM      <= 1'b0;
            MemWrite_MEM     <= 1'b0;
            MemWriteData_MEM <= '0;
        end else if (!StallAll) begin
            ALUOut_MEM       <= ALUOut_EX;
            RegWrite_MEM     <= regWriteNonZero;
            RegWriteAddr_MEM <= RegWriteAddr_EX;
            MemRead_MEM      <= MemRead_EX;
            // Load wins when both flags are set.
            MemWrite_MEM     <= MemWrite_EX & ~MemRead_EX;
            MemWriteData_MEM <= MemWriteData_EX;
        end
    end

    // MEM/WB register: bubble on stall, abandoned load writes back 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWriteData_WB <= '0;
            RegWrite_WB     <= 1'b0;
            RegWriteAddr_WB <= '0;
        end else if (StallAll) begin
            RegWrite_WB <= 1'b0;
        end else begin
            RegWrite_WB     <= RegWrite_MEM;
            RegWriteAddr_WB <= RegWriteAddr_MEM;
            if (MemRead_MEM) RegWriteData_WB <= timeoutHit ? '0 : MemReadData;
            else             RegWriteData_WB <= ALUOut_MEM;
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [31:0] luCnt, mwCnt;

    // Saturating stall statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            luCnt <= '0;
            mwCnt <= '0;
        end else begin
            if (Bubble_ID_EX && luCnt != 32'hFFFF_FFFF) luCnt <= luCnt + 32'd1;
            if (StallAll && mwCnt != 32'hFFFF_FFFF)     mwCnt <= mwCnt + 32'd1;
        end
    end

    assign LoadUseCount = luCnt;
    assign MemWaitCount = mwCnt;
`else
    assign LoadUseCount = '0;
    assign MemWaitCount = '0;
`endif

endmodule
